// File: rtl/miim_pkg.sv
// Shared MII management definitions: FSM states, frame field codes and lengths.
// Latency: n/a (package only).
// Backpressure: n/a.
package miim_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } miim_state_e;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int PREAMBLE_LEN = 32;
    localparam int FRAME_LEN    = 32;
    localparam int HDR_LEN      = 14;
    localparam int TA_LEN       = 2;
    localparam int DATA_LEN     = FRAME_LEN - HDR_LEN - TA_LEN;

    // Read frames carry TA=10 and zero data too; they are never driven because padoe is low then.
    function automatic logic [31:0] build_frame(input logic        write,
                                                input logic [4:0]  phy_addr,
                                                input logic [4:0]  reg_addr,
                                                input logic [15:0] wdata);
        return {ST_CODE, (write ? OP_WRITE : OP_READ), phy_addr, reg_addr,
                2'b10, (write ? wdata : 16'h0000)};
    endfunction

endpackage

// File: rtl/miim_clkgen.sv
// MDC divider: low for CLK_DIV clocks then high for CLK_DIV clocks while enabled.
// Latency: first low half starts on the first enabled cycle.
// Backpressure: none; rise/fall strobes flag the cycle before MDC changes level.
module miim_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       half_end;

    assign half_end = en && (div_cnt == DIV_LAST);
    assign rise     = half_end && !mdc;
    assign fall     = half_end && mdc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            mdc     <= 1'b0;
        end else if (!en) begin
            div_cnt <= 8'd0;
            mdc     <= 1'b0;
        end else if (half_end) begin
            div_cnt <= 8'd0;
            mdc     <= !mdc;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/miim_mgmt_ctrl.sv
// MII management (MDIO) master: serialises one clause-22 read/write frame per command.
// Latency: rsp_valid_o at accept + 1 + (64 or 32) * 2 * CLK_DIV clocks.
// Backpressure: cmd_ready_o low while a frame is in flight; next command may land in DONE.
module miim_mgmt_ctrl
    import miim_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_phy_addr_i,
    input  logic [4:0]  cmd_reg_addr_i,
    input  logic [15:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mdc_pad_o,
    output logic        md_pad_o,
    output logic        md_padoe_o,
    input  logic        md_pad_i
);

    miim_state_e state;
    logic [5:0]  bit_cnt;
    logic [31:0] frame_sr;
    logic [31:0] cmd_frame;
    logic [15:0] rdata_sr;
    logic        is_write;
    logic        ta_err;
    logic        accept;
    logic        clk_en;
    logic        mdc_rise;
    logic        mdc_fall;
    logic        last_bit;

    assign cmd_ready_o = (state == S_IDLE) || (state == S_DONE);
    assign rsp_valid_o = (state == S_DONE);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign clk_en      = !cmd_ready_o;
    assign cmd_frame   = build_frame(cmd_write_i, cmd_phy_addr_i, cmd_reg_addr_i, cmd_wdata_i);

    miim_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .en    (clk_en),
        .mdc   (mdc_pad_o),
        .rise  (mdc_rise),
        .fall  (mdc_fall)
    );

    // bit_cnt restarts every phase, so it never exceeds 31 inside a frame.
    always_comb begin
        last_bit = 1'b0;
        case (state)
            S_PRE:   last_bit = (bit_cnt == 6'(PREAMBLE_LEN - 1));
            S_HDR:   last_bit = (bit_cnt == 6'(HDR_LEN - 1));
            S_TA:    last_bit = (bit_cnt == 6'(TA_LEN - 1));
            S_DATA:  last_bit = (bit_cnt == 6'(DATA_LEN - 1));
            default: last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= S_IDLE;
            bit_cnt     <= 6'd0;
            frame_sr    <= 32'd0;
            rdata_sr    <= 16'd0;
            is_write    <= 1'b0;
            ta_err      <= 1'b0;
            md_pad_o    <= 1'b0;
            md_padoe_o  <= 1'b0;
            rsp_rdata_o <= 16'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                is_write   <= cmd_write_i;
                bit_cnt    <= 6'd0;
                ta_err     <= 1'b0;
                md_padoe_o <= 1'b1;
                if (PREAMBLE_EN) begin
                    state    <= S_PRE;
                    md_pad_o <= 1'b1;
                    frame_sr <= cmd_frame;
                end else begin
                    state    <= S_HDR;
                    md_pad_o <= cmd_frame[31];
                    frame_sr <= {cmd_frame[30:0], 1'b0};
                end
            end else if (state == S_DONE) begin
                state <= S_IDLE;
            end else if (mdc_fall) begin
                bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                if (last_bit) begin
                    case (state)
                        S_PRE:   state <= S_HDR;
                        S_HDR:   state <= S_TA;
                        S_TA:    state <= S_DATA;
                        S_DATA:  state <= S_DONE;
                        default: state <= S_IDLE;
                    endcase
                end
                if (state == S_DATA && last_bit) begin
                    md_pad_o   <= 1'b0;
                    md_padoe_o <= 1'b0;
                    rsp_err_o  <= !is_write && ta_err;
                    if (!is_write) begin
                        rsp_rdata_o <= rdata_sr;
                    end
                end else if (state != S_PRE || last_bit) begin
                    md_pad_o <= frame_sr[31];
                    frame_sr <= {frame_sr[30:0], 1'b0};
                end
                // Reads release the line from the first turnaround bit onward.
                if (state == S_HDR && last_bit && !is_write) begin
                    md_padoe_o <= 1'b0;
                end
            end

            if (mdc_rise) begin
                if (state == S_TA && bit_cnt == 6'd1 && !is_write) begin
                    ta_err <= md_pad_i;
                end
                if (state == S_DATA) begin
                    rdata_sr <= {rdata_sr[14:0], md_pad_i};
                end
            end
        end
    end

endmodule

// File: tb/tb_miim_mgmt_ctrl.sv
// Bench for miim_mgmt_ctrl: two instances (CLK_DIV=4 with preamble, CLK_DIV=2 without)
// checked every cycle against a frame-timing model plus literal spot checks.
module tb_miim_mgmt_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  cmd_valid, cmd_write, rdy, vld, err, mdc, md, oe, md_in;
    logic [4:0]  cmd_phy   [2];
    logic [4:0]  cmd_reg   [2];
    logic [15:0] cmd_wdata [2];
    logic [15:0] rdata     [2];

    miim_mgmt_ctrl #(.CLK_DIV(4), .PREAMBLE_EN(1'b1)) dut0 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(rdy[0]), .cmd_write_i(cmd_write[0]),
        .cmd_phy_addr_i(cmd_phy[0]), .cmd_reg_addr_i(cmd_reg[0]), .cmd_wdata_i(cmd_wdata[0]),
        .rsp_valid_o(vld[0]), .rsp_rdata_o(rdata[0]), .rsp_err_o(err[0]),
        .mdc_pad_o(mdc[0]), .md_pad_o(md[0]), .md_padoe_o(oe[0]), .md_pad_i(md_in[0])
    );

    miim_mgmt_ctrl #(.CLK_DIV(2), .PREAMBLE_EN(1'b0)) dut1 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(rdy[1]), .cmd_write_i(cmd_write[1]),
        .cmd_phy_addr_i(cmd_phy[1]), .cmd_reg_addr_i(cmd_reg[1]), .cmd_wdata_i(cmd_wdata[1]),
        .rsp_valid_o(vld[1]), .rsp_rdata_o(rdata[1]), .rsp_err_o(err[1]),
        .mdc_pad_o(mdc[1]), .md_pad_o(md[1]), .md_padoe_o(oe[1]), .md_pad_i(md_in[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state per instance
    bit          m_busy   [2];
    int          m_acc    [2];
    bit          m_w      [2];
    logic [31:0] m_frame  [2];
    bit          m_ta2    [2];
    logic [15:0] m_rd     [2];
    logic [15:0] exp_rdata[2];
    int          acc_cnt  [2];
    int          done_cnt [2];
    int          last_acc [2];
    int          last_done[2];
    logic [63:0] stream_obs[2];
    bit          prev_mdc [2];
    // PHY response to offer for the next read accepted
    bit          r_ta2    [2];
    logic [15:0] r_data   [2];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int pre_of(input int d);
        return (d == 0) ? 32 : 0;
    endfunction

    // Reference model and per-cycle compare
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int D, pre, L, k, b, ph;
            bit e_rdy, e_vld, e_mdc, e_oe, e_md, chk_md;
            D = div_of(d);
            pre = pre_of(d);
            L = (pre + 32) * 2 * D;
            if (!rst_n) begin
                m_busy[d] = 0;
                exp_rdata[d] = 16'h0;
                prev_mdc[d] = 0;
                chk("rst_ready", d, 32'(rdy[d]), 32'd1);
                chk("rst_valid", d, 32'(vld[d]), 32'd0);
                chk("rst_mdc", d, 32'(mdc[d]), 32'd0);
                chk("rst_md", d, 32'(md[d]), 32'd0);
                chk("rst_oe", d, 32'(oe[d]), 32'd0);
                chk("rst_rdata", d, 32'(rdata[d]), 32'd0);
                chk("rst_err", d, 32'(err[d]), 32'd0);
                continue;
            end
            e_rdy = 1; e_vld = 0; e_mdc = 0; e_oe = 0; e_md = 0; chk_md = 1;
            if (m_busy[d]) begin
                k = cyc - m_acc[d];
                if (k == L + 1) begin
                    e_vld = 1;
                    if (!m_w[d]) exp_rdata[d] = m_rd[d];
                    m_busy[d] = 0;
                    last_done[d] = cyc;
                    done_cnt[d]++;
                end else begin
                    e_rdy = 0;
                    b = (k - 1) / (2 * D);
                    ph = (k - 1) % (2 * D);
                    e_mdc = (ph >= D);
                    e_oe = m_w[d] || (b < pre + 14);
                    e_md = (b < pre) ? 1'b1 : m_frame[d][31 - (b - pre)];
                    chk_md = e_oe;
                end
            end
            chk("ready", d, 32'(rdy[d]), 32'(e_rdy));
            chk("valid", d, 32'(vld[d]), 32'(e_vld));
            chk("mdc", d, 32'(mdc[d]), 32'(e_mdc));
            chk("padoe", d, 32'(oe[d]), 32'(e_oe));
            if (chk_md) chk("md_out", d, 32'(md[d]), 32'(e_md));
            chk("rdata", d, 32'(rdata[d]), 32'(exp_rdata[d]));
            if (e_vld) chk("err", d, 32'(err[d]), m_w[d] ? 32'd0 : 32'(m_ta2[d]));
            if (mdc[d] && !prev_mdc[d]) stream_obs[d] = {stream_obs[d][62:0], md[d]};
            prev_mdc[d] = mdc[d];
            if (e_rdy && cmd_valid[d]) begin
                m_busy[d] = 1;
                m_acc[d] = cyc;
                m_w[d] = cmd_write[d];
                m_frame[d] = {2'b01, (cmd_write[d] ? 2'b01 : 2'b10), cmd_phy[d], cmd_reg[d],
                              2'b10, (cmd_write[d] ? cmd_wdata[d] : 16'h0)};
                m_ta2[d] = r_ta2[d];
                m_rd[d] = r_data[d];
                acc_cnt[d]++;
                last_acc[d] = cyc;
                stream_obs[d] = 64'h0;
            end
        end
    end

    // PHY model: pull-up when idle, drives TA2 and data for reads across whole bit periods
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            int k, b, pre;
            pre = pre_of(d);
            md_in[d] = 1'b1;
            if (m_busy[d] && !m_w[d]) begin
                k = cyc - m_acc[d];
                b = (k - 1) / (2 * div_of(d));
                if (b == pre + 15) md_in[d] = m_ta2[d];
                else if (b >= pre + 16 && b < pre + 32) md_in[d] = m_rd[d][15 - (b - pre - 16)];
            end
        end
    end

    task automatic issue(input int d, input bit w, input logic [4:0] p, input logic [4:0] r,
                         input logic [15:0] wd, input bit ta2, input logic [15:0] rd, input bit hold);
        int n0, t;
        n0 = acc_cnt[d];
        cmd_write[d] = w; cmd_phy[d] = p; cmd_reg[d] = r; cmd_wdata[d] = wd;
        r_ta2[d] = ta2; r_data[d] = rd;
        cmd_valid[d] = 1'b1;
        t = 0;
        while (acc_cnt[d] == n0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("accept_timeout", d, 32'(acc_cnt[d] != n0), 32'd1);
        if (!hold) cmd_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int t;
        t = 0;
        while (m_busy[d] && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("done_timeout", d, 32'(m_busy[d]), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, n0, t;
        rst_n = 1'b0;
        cmd_valid = '0; cmd_write = '0; md_in = '1;
        for (int d = 0; d < 2; d++) begin
            cmd_phy[d] = '0; cmd_reg[d] = '0; cmd_wdata[d] = '0;
            r_ta2[d] = 0; r_data[d] = '0;
            acc_cnt[d] = 0; done_cnt[d] = 0; m_busy[d] = 0;
            exp_rdata[d] = '0; stream_obs[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_lit", 0, 32'(rdy[0]), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed write: exact serial stream and latency
        issue(0, 1, 5'h01, 5'h00, 16'h1200, 0, 16'h0, 0);
        wait_done(0);
        chk("stream_lit", 0, 32'(stream_obs[0][63:32]), 32'hFFFF_FFFF);
        chk("stream_lit", 0, stream_obs[0][31:0], 32'b0101_00001_00000_10_0001001000000000);
        chk("latency_513", 0, 32'(last_done[0] - last_acc[0]), 32'd513);
        chk("write_err_lit", 0, 32'(err[0]), 32'd0);

        // Read with a responding PHY
        issue(0, 0, 5'h1F, 5'h02, 16'hDEAD, 0, 16'h0141, 0);
        wait_done(0);
        chk("read_rdata_lit", 0, 32'(rdata[0]), 32'h0141);
        chk("read_err_lit", 0, 32'(err[0]), 32'd0);

        // Read with no PHY present: line floats high
        issue(0, 0, 5'h03, 5'h04, 16'h0, 1, 16'hFFFF, 0);
        wait_done(0);
        chk("nophy_err_lit", 0, 32'(err[0]), 32'd1);
        chk("nophy_rdata_lit", 0, 32'(rdata[0]), 32'hFFFF);

        // Following write keeps read data, reports no error
        issue(0, 1, 5'h07, 5'h09, 16'hA5A5, 0, 16'h0, 0);
        wait_done(0);
        chk("write_keeps_rdata", 0, 32'(rdata[0]), 32'hFFFF);
        chk("write_err_clear", 0, 32'(err[0]), 32'd0);

        // No preamble, CLK_DIV=2, back-to-back accept in DONE
        issue(1, 1, 5'h02, 5'h11, 16'h1234, 0, 16'h0, 0);
        a1 = last_acc[1];
        issue(1, 0, 5'h05, 5'h06, 16'h0, 0, 16'hBEEF, 0);
        chk("latency_129", 1, 32'(last_done[1] - a1), 32'd129);
        chk("b2b_accept_in_done", 1, 32'(last_acc[1]), 32'(last_done[1]));
        wait_done(1);
        chk("b2b_rdata_lit", 1, 32'(rdata[1]), 32'hBEEF);

        // cmd_valid held with changing fields: second command taken in DONE
        n0 = acc_cnt[0];
        issue(0, 1, 5'h0A, 5'h0B, 16'h5555, 0, 16'h0, 1);
        a1 = last_acc[0];
        t = 0;
        while (acc_cnt[0] < n0 + 2 && t < 3000) begin
            @(posedge clk); #1;
            cmd_write[0] = 1'($urandom); cmd_phy[0] = 5'($urandom); cmd_reg[0] = 5'($urandom);
            cmd_wdata[0] = 16'($urandom); r_ta2[0] = ($urandom_range(0, 3) == 0);
            r_data[0] = 16'($urandom);
            t++;
        end
        cmd_valid[0] = 1'b0;
        chk("held_accept_count", 0, 32'(acc_cnt[0] - n0), 32'd2);
        chk("held_second_at_done", 0, 32'(last_acc[0] - a1), 32'd513);
        wait_done(0);

        // Randomised traffic on both instances
        for (int i = 0; i < 24; i++) begin
            int d;
            d = (i < 8) ? 0 : 1;
            issue(d, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0), 16'($urandom), 0);
            if ($urandom_range(0, 1) == 1) begin
                wait_done(d);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        end
        wait_done(0);
        wait_done(1);

        // Reset in the middle of a read's data phase
        issue(0, 0, 5'h12, 5'h13, 16'h0, 0, 16'h3C3C, 0);
        t = 0;
        while (cyc - last_acc[0] < 1 + 52 * 8 && t < 3000) begin @(posedge clk); t++; end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mdc", 0, 32'(mdc[0]), 32'd0);
        chk("async_rst_oe", 0, 32'(oe[0]), 32'd0);
        chk("async_rst_md", 0, 32'(md[0]), 32'd0);
        chk("async_rst_ready", 0, 32'(rdy[0]), 32'd1);
        chk("async_rst_rdata", 0, 32'(rdata[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n0 = done_cnt[0];
        issue(0, 0, 5'h12, 5'h13, 16'h0, 0, 16'h3C3C, 0);
        wait_done(0);
        chk("after_rst_one_done", 0, 32'(done_cnt[0] - n0), 32'd1);
        chk("after_rst_rdata_lit", 0, 32'(rdata[0]), 32'h3C3C);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/miim_mgmt_ctrl.md
MIIM_MGMT_CTRL -- requirements
Module: miim_mgmt_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: wb_clk_i cycles per MDC half-period, legal range 2..255.
REQ-002 SHALL have parameter PREAMBLE_EN, default 1: 1 sends a 32-bit preamble, 0 suppresses it.
REQ-003 SHALL have port wb_clk_i  input  1  single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port wb_rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid_i  input  1  command request.
REQ-006 SHALL have port cmd_ready_o  output  1  controller can accept a command.
REQ-007 SHALL have port cmd_write_i  input  1  1 = write frame, 0 = read frame.
REQ-008 SHALL have port cmd_phy_addr_i  input  5  PHY address.
REQ-009 SHALL have port cmd_reg_addr_i  input  5  register address.
REQ-010 SHALL have port cmd_wdata_i  input  16  write data.
REQ-011 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata_o  output  16  read data, held until the next read completes.
REQ-013 SHALL have port rsp_err_o  output  1  read turnaround error, valid with rsp_valid_o.
REQ-014 SHALL have port mdc_pad_o  output  1  management clock.
REQ-015 SHALL have port md_pad_o  output  1  MDIO drive value.
REQ-016 SHALL have port md_padoe_o  output  1  MDIO output enable.
REQ-017 SHALL have port md_pad_i  input  1  MDIO sampled value.

Function
REQ-018 SHALL accept a command only on a cycle where cmd_valid_i and cmd_ready_o are both 1, capturing all cmd_* fields that cycle.
REQ-019 SHALL keep cmd_ready_o high in IDLE and DONE and low in all other states.
REQ-020 SHALL sequence the FSM IDLE -> PRE (skipped if PREAMBLE_EN=0) -> HDR -> TA -> DATA -> DONE -> IDLE.
- HDR: ST=01, OP (01 write, 10 read), PHYAD, REGAD, all MSB first.
- TA and DATA: 2 and 16 bits.
REQ-021 SHALL make each bit period 2*CLK_DIV clocks: MDC low for CLK_DIV clocks, then high for CLK_DIV clocks.
REQ-022 SHALL start the first period on the cycle after acceptance.
REQ-023 SHALL hold MDC low in IDLE and DONE.
REQ-024 SHALL update md_pad_o only on the cycle MDC goes low and SHALL sample md_pad_i only on the cycle MDC goes high.
REQ-025 SHALL drive md_padoe_o=1 for every write-frame bit, with TA=10.
REQ-026 SHALL, on reads, drive md_padoe_o=1 through REGAD and 0 from the first TA bit through DATA.
REQ-027 SHALL, on reads, set rsp_err_o=1 when the second TA bit samples 1.
REQ-028 SHALL update rsp_rdata_o on every read regardless of rsp_err_o.
REQ-029 SHALL set rsp_err_o=0 for writes and SHALL leave rsp_rdata_o unchanged on writes.
REQ-030 SHALL enter DONE when the last MDC high half ends, and SHALL assert rsp_valid_o and drive md_padoe_o=0, md_pad_o=0 in that cycle.
REQ-031 SHALL assert rsp_valid_o at acceptance cycle + 1 + N*2*CLK_DIV, where N=64 (PREAMBLE_EN=1) or 32.
REQ-032 SHALL accept a command arriving in the DONE cycle, starting the next frame with no idle cycle.
REQ-033 SHALL ignore cmd_valid_i while busy; no command is queued or lost.
REQ-034 SHALL track progress with a 6-bit bit counter that never wraps within a frame.

Reset
REQ-035 SHALL, on wb_rst_n_i low, immediately force:
- FSM=IDLE.
- mdc_pad_o=0, md_pad_o=0, md_padoe_o=0.
- cmd_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- all counters to 0.
REQ-036 SHALL abort any frame interrupted by reset silently, with no rsp_valid_o.
REQ-037 SHALL begin operation on the first rising edge after reset deassertion.

Structure
REQ-038 SHALL take from shared package miim_pkg:
- state enum;
- ST_CODE (2'b01), OP_WRITE (2'b01), OP_READ (2'b10);
- PREAMBLE_LEN (32), FRAME_LEN (32).
REQ-039 SHALL place the MDC divider in sub-module miim_clkgen, which emits mdc, a rise strobe and a fall strobe, and is enabled only outside IDLE/DONE.

Verification
REQ-040 Write, CLK_DIV=4, PREAMBLE_EN=1, phy=5'h01, reg=5'h00, data=16'h1200 -> MDIO serial stream 32x1, then 0101_00001_00000_10_0001001000000000 with padoe=1; rsp_valid 513 clocks after accept; rsp_err=0.
REQ-041 Read, phy=5'h1F, reg=5'h02, PHY model returns TA bit 0 and data 16'h0141 -> padoe drops at the TA start; rsp_rdata=16'h0141; rsp_err=0.
REQ-042 Read with MDIO pulled high and no PHY -> rsp_err=1, rsp_rdata=16'hFFFF.
REQ-043 PREAMBLE_EN=0, CLK_DIV=2, write -> rsp_valid 129 clocks after accept; back-to-back command issued on the DONE cycle starts the next frame the following cycle.
REQ-044 wb_rst_n_i pulsed low mid-DATA of a read -> all outputs at reset values the same cycle; no rsp_valid; the next command completes normally.
REQ-045 cmd_valid held high during a frame with changing fields -> only the first command executes; the second is accepted in DONE with fields sampled at that cycle.
